// File: rtl/bus_master_if_pkg.sv
// Shared bus constants for the master, arbiter and slaves: widths,
// active-low levels, direction levels and the master state encoding.
package bus_master_if_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } bus_state_e;

    // Where a finished access goes: hold the result while the pipeline is stalled.
    function automatic bus_state_e done_state(input logic stall);
        return stall ? STALL : IDLE;
    endfunction

endpackage

// File: rtl/bus_master_if_if.sv
// Requester-side and bus-side signals of the bus master, grouped with
// a master modport (the block) and a slave modport (its environment).
interface bus_master_if_if;
    import bus_master_if_pkg::*;

    logic              stall;
    logic              flush;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        input  stall, flush, addr, as_, rw, wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_,
        output busy, rd_data,
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );

    modport slave (
        output stall, flush, addr, as_, rw, wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_,
        input  busy, rd_data,
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );

endinterface

// File: rtl/bus_master_if.sv
// Bus master: turns a requester strobe into an arbitrated, strobed bus
// access and returns read data, holding it while the pipeline stalls.
module bus_master_if
    import bus_master_if_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    bus_master_if_if.master bif
);

    bus_state_e        r_state;
    logic              r_bus_req_;
    logic              r_bus_as_;
    logic              r_bus_rw;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wr_data;
    logic [DATA_W-1:0] r_rd_buf;
    logic              w_busy;
    logic [DATA_W-1:0] w_rd_data;

    // State machine, latched bus request fields and read-data holding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_bus_req_    <= DISABLE_;
            r_bus_as_     <= DISABLE_;
            r_bus_rw      <= READ;
            r_bus_addr    <= {ADDR_W{1'b0}};
            r_bus_wr_data <= {DATA_W{1'b0}};
            r_rd_buf      <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if ((bif.as_ == ENABLE_) && (bif.flush == 1'b0)) begin
                        r_bus_req_    <= ENABLE_;
                        r_bus_addr    <= bif.addr;
                        r_bus_rw      <= bif.rw;
                        r_bus_wr_data <= bif.wr_data;
                        r_state       <= REQ;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                REQ: begin
                    if (bif.bus_grnt_ == ENABLE_) begin
                        r_bus_as_ <= ENABLE_;
                        r_state   <= ACCESS;
                    end else begin
                        r_state <= REQ;
                    end
                end
                ACCESS: begin
                    // The strobe is a single-cycle pulse even for a zero-wait slave.
                    r_bus_as_ <= DISABLE_;
                    if (bif.bus_rdy_ == ENABLE_) begin
                        r_rd_buf   <= bif.bus_rd_data;
                        r_bus_req_ <= DISABLE_;
                        r_state    <= done_state(bif.stall);
                    end else begin
                        r_state <= ACCESS;
                    end
                end
                STALL: begin
                    if (bif.stall == 1'b0) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= STALL;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Requester handshake: busy and read data respond in the same cycle.
    always_comb begin
        w_busy    = 1'b0;
        w_rd_data = r_rd_buf;
        case (r_state)
            IDLE: begin
                if ((bif.as_ == ENABLE_) && (bif.flush == 1'b0)) begin
                    w_busy = 1'b1;
                end else begin
                    w_busy = 1'b0;
                end
            end
            REQ: begin
                w_busy = 1'b1;
            end
            ACCESS: begin
                if (bif.bus_rdy_ == ENABLE_) begin
                    w_busy    = 1'b0;
                    w_rd_data = bif.bus_rd_data;
                end else begin
                    w_busy = 1'b1;
                end
            end
            STALL: begin
                w_busy = 1'b0;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign bif.busy        = w_busy;
    assign bif.rd_data     = w_rd_data;
    assign bif.bus_req_    = r_bus_req_;
    assign bif.bus_as_     = r_bus_as_;
    assign bif.bus_rw      = r_bus_rw;
    assign bif.bus_addr    = r_bus_addr;
    assign bif.bus_wr_data = r_bus_wr_data;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: inputs change on the falling edge and
// outputs are sampled 1 time unit later, so rising-edge updates are settled.
module tb_bus_master_if;
    import bus_master_if_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    bus_master_if_if bif();

    bus_master_if dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        bif.stall       = 1'b0;
        bif.flush       = 1'b0;
        bif.addr        = 30'h0;
        bif.as_         = 1'b1;
        bif.rw          = 1'b1;
        bif.wr_data     = 32'h0;
        bif.bus_grnt_   = 1'b1;
        bif.bus_rd_data = 32'h0;
        bif.bus_rdy_    = 1'b1;
    endtask

    task automatic test_reset;
        #1;
        n_vec++; if (bif.bus_req_ !== 1'b1) begin n_err++; $display("FAIL rst_bus_req_: got %0b want 1", bif.bus_req_); end
        n_vec++; if (bif.bus_as_ !== 1'b1) begin n_err++; $display("FAIL rst_bus_as_: got %0b want 1", bif.bus_as_); end
        n_vec++; if (bif.bus_rw !== 1'b1) begin n_err++; $display("FAIL rst_bus_rw: got %0b want 1", bif.bus_rw); end
        n_vec++; if (bif.bus_addr !== 30'h0) begin n_err++; $display("FAIL rst_bus_addr: got %h want 0", bif.bus_addr); end
        n_vec++; if (bif.bus_wr_data !== 32'h0) begin n_err++; $display("FAIL rst_bus_wr_data: got %h want 0", bif.bus_wr_data); end
        n_vec++; if (bif.rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd_data: got %h want 0", bif.rd_data); end
        n_vec++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", bif.busy); end
        n_vec++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d want IDLE", dut.r_state); end
    endtask

    // Read, grant two cycles late, ready three cycles after the strobe.
    task automatic test_read;
        int as_low;
        as_low = 0;
        bif.addr = 30'h0000_0100; bif.rw = 1'b1; bif.as_ = 1'b0;
        #1;
        n_vec++; if (bif.busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_idle: got %0b want 1", bif.busy); end
        for (int i = 0; i < 3; i++) begin
            tick;
            bif.as_ = 1'b1;
            bif.bus_grnt_ = (i == 2) ? 1'b0 : 1'b1;
            #1;
            if (bif.bus_as_ === 1'b0) as_low++;
            n_vec++; if (bif.bus_req_ !== 1'b0 || bif.busy !== 1'b1) begin n_err++; $display("FAIL rd_req_phase%0d: got req_=%0b busy=%0b want 0/1", i, bif.bus_req_, bif.busy); end
        end
        n_vec++; if (bif.bus_addr !== 30'h0000_0100 || bif.bus_rw !== 1'b1) begin n_err++; $display("FAIL rd_latch: got %h/%0b want 00000100/1", bif.bus_addr, bif.bus_rw); end
        for (int i = 0; i < 4; i++) begin
            tick;
            bif.bus_grnt_ = 1'b1;
            if (i == 3) begin bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hDEAD_BEEF; end
            #1;
            if (bif.bus_as_ === 1'b0) as_low++;
            n_vec++; if (bif.bus_req_ !== 1'b0) begin n_err++; $display("FAIL rd_req_access%0d: got %0b want 0", i, bif.bus_req_); end
            n_vec++; if (bif.busy !== ((i == 3) ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL rd_busy_access%0d: got %0b want %0b", i, bif.busy, (i != 3)); end
        end
        n_vec++; if (bif.rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data_pass: got %h want deadbeef", bif.rd_data); end
        tick;
        bif.bus_rdy_ = 1'b1; bif.bus_rd_data = 32'h0;
        #1;
        n_vec++; if (as_low !== 1) begin n_err++; $display("FAIL rd_as_width: got %0d want 1", as_low); end
        n_vec++; if (dut.r_state !== IDLE || bif.bus_req_ !== 1'b1) begin n_err++; $display("FAIL rd_done: got state=%0d req_=%0b want IDLE/1", dut.r_state, bif.bus_req_); end
        n_vec++; if (bif.rd_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_hold: got %h want deadbeef", bif.rd_data); end
    endtask

    // Write to the top address with immediate grant and a zero-wait slave.
    task automatic test_write;
        bif.addr = 30'h3FFF_FFFF; bif.wr_data = 32'h1234_5678; bif.rw = 1'b0; bif.as_ = 1'b0;
        bif.bus_grnt_ = 1'b0;
        #1;
        n_vec++; if (bif.busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_c1: got %0b want 1", bif.busy); end
        tick;
        bif.as_ = 1'b1; bif.addr = 30'h0000_0005; bif.wr_data = 32'hFFFF_0000; bif.rw = 1'b1;
        #1;
        n_vec++; if (bif.busy !== 1'b1 || bif.bus_req_ !== 1'b0) begin n_err++; $display("FAIL wr_c2: got busy=%0b req_=%0b want 1/0", bif.busy, bif.bus_req_); end
        n_vec++; if (bif.bus_rw !== 1'b0 || bif.bus_addr !== 30'h3FFF_FFFF || bif.bus_wr_data !== 32'h1234_5678) begin n_err++; $display("FAIL wr_latch: got rw=%0b %h %h want 0 3fffffff 12345678", bif.bus_rw, bif.bus_addr, bif.bus_wr_data); end
        tick;
        bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hA5A5_0001;
        #1;
        n_vec++; if (bif.bus_as_ !== 1'b0 || bif.busy !== 1'b0) begin n_err++; $display("FAIL wr_done_c3: got as_=%0b busy=%0b want 0/0", bif.bus_as_, bif.busy); end
        n_vec++; if (bif.bus_addr !== 30'h3FFF_FFFF || bif.bus_wr_data !== 32'h1234_5678) begin n_err++; $display("FAIL wr_hold: got %h %h want 3fffffff 12345678", bif.bus_addr, bif.bus_wr_data); end
        tick;
        bif.bus_rdy_ = 1'b1; bif.bus_rd_data = 32'h0;
        #1;
        n_vec++; if (bif.bus_as_ !== 1'b1 || bif.bus_req_ !== 1'b1 || dut.r_state !== IDLE) begin n_err++; $display("FAIL wr_after: got as_=%0b req_=%0b state=%0d want 1/1/IDLE", bif.bus_as_, bif.bus_req_, dut.r_state); end
        n_vec++; if (bif.rd_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL wr_capture: got %h want a5a50001", bif.rd_data); end
    endtask

    // Read completing with stall held; rd_data must stay at the captured value.
    task automatic test_stall;
        bif.addr = 30'h0000_0040; bif.rw = 1'b1; bif.as_ = 1'b0;
        tick;
        bif.as_ = 1'b1; bif.bus_grnt_ = 1'b0;
        tick;
        bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hCAFE_F00D; bif.stall = 1'b1;
        #1;
        n_vec++; if (bif.rd_data !== 32'hCAFE_F00D || bif.busy !== 1'b0) begin n_err++; $display("FAIL st_pass: got %h busy=%0b want cafef00d/0", bif.rd_data, bif.busy); end
        for (int i = 0; i < 3; i++) begin
            tick;
            bif.bus_rdy_ = 1'b1; bif.bus_rd_data = 32'h0; bif.as_ = 1'b0;
            #1;
            n_vec++; if (dut.r_state !== STALL || bif.rd_data !== 32'hCAFE_F00D || bif.busy !== 1'b0 || bif.bus_req_ !== 1'b1) begin n_err++; $display("FAIL st_hold%0d: got state=%0d rd=%h busy=%0b req_=%0b want STALL cafef00d 0 1", i, dut.r_state, bif.rd_data, bif.busy, bif.bus_req_); end
        end
        bif.stall = 1'b0; bif.as_ = 1'b1;
        tick;
        #1;
        n_vec++; if (dut.r_state !== IDLE || bif.rd_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL st_release: got state=%0d rd=%h want IDLE cafef00d", dut.r_state, bif.rd_data); end
    endtask

    // Flush blocks a new request in IDLE but not an access already accepted.
    task automatic test_flush;
        bif.addr = 30'h0000_0200; bif.rw = 1'b1; bif.as_ = 1'b0; bif.flush = 1'b1;
        #1;
        n_vec++; if (bif.busy !== 1'b0) begin n_err++; $display("FAIL fl_busy_idle: got %0b want 0", bif.busy); end
        tick;
        #1;
        n_vec++; if (bif.bus_req_ !== 1'b1 || dut.r_state !== IDLE) begin n_err++; $display("FAIL fl_noreq: got req_=%0b state=%0d want 1/IDLE", bif.bus_req_, dut.r_state); end
        bif.flush = 1'b0;
        tick;
        bif.as_ = 1'b1; bif.flush = 1'b1;
        #1;
        n_vec++; if (bif.busy !== 1'b1 || bif.bus_req_ !== 1'b0) begin n_err++; $display("FAIL fl_req: got busy=%0b req_=%0b want 1/0", bif.busy, bif.bus_req_); end
        bif.bus_grnt_ = 1'b0;
        tick;
        bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h0BAD_F1A5;
        #1;
        n_vec++; if (bif.busy !== 1'b0 || bif.rd_data !== 32'h0BAD_F1A5) begin n_err++; $display("FAIL fl_complete: got busy=%0b rd=%h want 0 0badf1a5", bif.busy, bif.rd_data); end
        tick;
        bif.bus_rdy_ = 1'b1; bif.flush = 1'b0;
        #1;
        n_vec++; if (dut.r_state !== IDLE || bif.bus_req_ !== 1'b1) begin n_err++; $display("FAIL fl_end: got state=%0d req_=%0b want IDLE/1", dut.r_state, bif.bus_req_); end
    endtask

    // Reset in ACCESS releases the bus without waiting for a clock edge.
    task automatic test_reset_mid;
        bif.addr = 30'h0000_0300; bif.rw = 1'b1; bif.as_ = 1'b0;
        tick;
        bif.as_ = 1'b1; bif.bus_grnt_ = 1'b0;
        tick;
        bif.bus_grnt_ = 1'b1;
        #1;
        n_vec++; if (bif.bus_as_ !== 1'b0 || bif.bus_req_ !== 1'b0) begin n_err++; $display("FAIL rm_pre: got as_=%0b req_=%0b want 0/0", bif.bus_as_, bif.bus_req_); end
        reset = 1'b0;
        #1;
        n_vec++; if (bif.bus_as_ !== 1'b1 || bif.bus_req_ !== 1'b1 || bif.busy !== 1'b0) begin n_err++; $display("FAIL rm_async: got as_=%0b req_=%0b busy=%0b want 1/1/0", bif.bus_as_, bif.bus_req_, bif.busy); end
        tick;
        reset = 1'b1;
        tick;
        tick;
        #1;
        n_vec++; if (dut.r_state !== IDLE || bif.bus_req_ !== 1'b1 || bif.busy !== 1'b0) begin n_err++; $display("FAIL rm_after: got state=%0d req_=%0b busy=%0b want IDLE/1/0", dut.r_state, bif.bus_req_, bif.busy); end
    endtask

    // Requester address changes mid-access; next request follows an idle cycle.
    task automatic test_addr_change;
        bif.addr = 30'h0ABC_DEF0; bif.rw = 1'b1; bif.as_ = 1'b0;
        tick;
        bif.addr = 30'h1111_1111; bif.bus_grnt_ = 1'b0;
        tick;
        bif.bus_grnt_ = 1'b1; bif.addr = 30'h2222_2222;
        #1;
        n_vec++; if (bif.bus_addr !== 30'h0ABC_DEF0) begin n_err++; $display("FAIL ac_a1: got %h want 0abcdef0", bif.bus_addr); end
        tick;
        bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h7777_0000;
        #1;
        n_vec++; if (bif.bus_addr !== 30'h0ABC_DEF0) begin n_err++; $display("FAIL ac_a2: got %h want 0abcdef0", bif.bus_addr); end
        tick;
        bif.bus_rdy_ = 1'b1;
        #1;
        n_vec++; if (bif.bus_req_ !== 1'b1 || bif.busy !== 1'b1 || bif.bus_addr !== 30'h0ABC_DEF0) begin n_err++; $display("FAIL ac_gap: got req_=%0b busy=%0b addr=%h want 1/1/0abcdef0", bif.bus_req_, bif.busy, bif.bus_addr); end
        tick;
        bif.as_ = 1'b1; bif.bus_grnt_ = 1'b0;
        #1;
        n_vec++; if (bif.bus_req_ !== 1'b0 || bif.bus_addr !== 30'h2222_2222) begin n_err++; $display("FAIL ac_next: got req_=%0b addr=%h want 0/22222222", bif.bus_req_, bif.bus_addr); end
        tick;
        bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b0;
        tick;
        bif.bus_rdy_ = 1'b1;
        #1;
        n_vec++; if (dut.r_state !== IDLE) begin n_err++; $display("FAIL ac_end: got %0d want IDLE", dut.r_state); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        tick;
        test_read();
        tick;
        test_write();
        tick;
        test_stall();
        tick;
        test_flush();
        tick;
        test_reset_mid();
        tick;
        test_addr_change();
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
